sram_burst: RTL and testbench
=============================

# sram_burst

Parametrised single-port synchronous SRAM with a shared tri-state data bus, built on the existing cs/we/oe chip-select interface. It adds configurable width and depth, auto-incrementing burst reads and writes of up to 2^BURST_BITS beats, and a hardware clear sequencer that zeroes the array after reset. It is the memory chip used by later lab datapaths and their testbenches.

## Interface
- ADDR_WIDTH, 7: address bits; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 8: word width.
- BURST_BITS, 3: width of burst_len; a burst is up to 2^BURST_BITS beats.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  chip select; no access is accepted while cs is low.
- we  input  1  write enable.
- oe  input  1  output enable (read request).
- address  input  ADDR_WIDTH  start address, sampled on the first beat only.
- burst_len  input  BURST_BITS  beats minus 1, sampled on the first beat only (0 = single access).
- data  inout  DATA_WIDTH  shared bus: the host drives it on writes, the block drives it on reads, and it is high-Z otherwise.
- busy  output  1  high while clearing; all accesses are ignored.
- valid  output  1  the block is driving valid read data on data.

## Operation
- States: CLEAR, IDLE, WR_BURST, RD_BURST. Internal registers: ptr (ADDR_WIDTH), beats_left (BURST_BITS), clr_ptr (ADDR_WIDTH), rd_reg (DATA_WIDTH).
- Reset sampled high: next state is CLEAR, clr_ptr=0, ptr=0, beats_left=0, valid=0, rd_reg=0, and the bus is released. Reset has priority over everything, including a burst in progress.
- CLEAR: writes 0 to mem[clr_ptr] each cycle and increments clr_ptr. After writing address 2^ADDR_WIDTH-1 it goes to IDLE. Host strobes are ignored.
- IDLE, cs&we&!oe: writes data to mem[address].
  - burst_len=0: stays in IDLE.
  - Otherwise: ptr=address+1, beats_left=burst_len, go to WR_BURST.
- WR_BURST: each cycle with cs&we&!oe, writes data to mem[ptr], increments ptr and decrements beats_left. Returns to IDLE after the beat where beats_left was 1.
- IDLE, cs&oe&!we: rd_reg=mem[address], valid=1.
  - burst_len=0: next state IDLE.
  - Otherwise: ptr=address+1, beats_left=burst_len, go to RD_BURST.
- RD_BURST: each cycle with cs&oe&!we, rd_reg=mem[ptr], increments ptr and decrements beats_left. Returns to IDLE after the beat where beats_left was 1.
- In IDLE with no read request, valid clears to 0 on the next edge.
- Burst abort: if cs falls, or the we/oe pattern changes mid-burst, the block returns to IDLE on that edge. No write happens, valid=0, and the remaining beats are dropped.
- cs&we&oe both high is illegal. It is treated as no access: no write, valid=0, bus not driven, and any burst is aborted.
- ptr arithmetic is modulo 2^ADDR_WIDTH, so a burst starting at depth-2 with burst_len=3 accesses depth-2, depth-1, 0, 1.
- Bus drive: data = rd_reg when valid&cs&oe&!we, else high-Z. Dropping cs or oe releases the bus combinationally.
- There is no write-through: a read presents the array content as of the sampling edge.

## Timing
- Reset values: busy=1 (from the first edge with reset high), valid=0, data high-Z. State is CLEAR once reset deasserts.
- Clear takes exactly 2^ADDR_WIDTH cycles after reset deasserts. busy falls on the edge that writes the last word. The first access is accepted on the following edge.
- Write latency: 0. The word is in the array at the sampling edge, so a read sampled on the next edge returns it.
- Read latency: 1 cycle. Data and valid are valid after the sampling edge and held for one full cycle per beat.
- Burst: one beat per cycle with no gaps, burst_len+1 beats total. valid stays high continuously for burst_len+1 cycles.
- Strobes and address must be stable around the rising edge. The host must drive data only for writes, to avoid contention.

## Test plan
- Reset clear: preload mem[5]=8'hAA via a write, pulse reset 1 cycle, wait 128 cycles -> busy high for exactly 128 cycles, then a read of 5 returns 8'h00.
- Single write/read: write 8'h81 to 7'h08 (burst_len=0), then read 7'h08 -> valid=1 and data=8'h81 one cycle after the read edge; bus high-Z once oe=0.
- Burst write/read: write 73, 19, 34, 5 starting at 0 with burst_len=3, then read the same burst -> 73, 19, 34, 5 on consecutive cycles with valid high 4 cycles.
- Wrap-around: burst write 1, 2, 3 at 126 with burst_len=2 -> mem[126]=1, mem[127]=2, mem[0]=3.
- Abort: start a 4-beat write at 16, drop cs after 2 beats -> only mem[16] and mem[17] are written, mem[18] unchanged; state returns to IDLE.
- Illegal and mid-op reset: cs&we&oe with data=8'hFF at 9 -> mem[9] unchanged and bus high-Z. Reset asserted mid read burst -> valid=0 next edge and busy=1.

Source files
------------

// File: rtl/sram_burst.sv
// sram_burst: single-port synchronous SRAM on a shared tri-state data bus.
// The memory zeroes itself after reset. It accepts single or auto-incrementing
// burst reads and writes through a cs/we/oe chip-select interface.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   cs         chip select; no access is accepted while low
//   we         write enable
//   oe         output enable (read request)
//   address    start address, sampled on the first beat of an access
//   burst_len  number of beats minus one, sampled on the first beat
//   data       shared bus: the host drives it on writes, this block drives it
//              on reads, and it is high-Z otherwise
//   busy       high while the clear sequencer owns the array
//   valid      the block is driving valid read data on data
module sram_burst #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [BURST_BITS-1:0] burst_len,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  valid
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StWrBurst,
    StRdBurst
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [BURST_BITS-1:0]  beats_left_q, beats_left_d;
  logic [ADDR_WIDTH-1:0]  clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0]  rd_reg_q, rd_reg_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic [DATA_WIDTH-1:0]  mem_q [Depth];

  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_waddr;
  logic [DATA_WIDTH-1:0]  mem_wdata;

  logic                   wr_req;
  logic                   rd_req;
  logic                   last_beat;

  // cs&we&oe matches neither request, so it is treated as no access.
  assign wr_req    = cs & we & ~oe;
  assign rd_req    = cs & oe & ~we;
  assign last_beat = (beats_left_q == BURST_BITS'(1));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    beats_left_d = beats_left_q;
    clr_ptr_d    = clr_ptr_q;
    rd_reg_d     = rd_reg_q;
    valid_d      = 1'b0;
    busy_d       = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = ptr_q;
    mem_wdata    = data;

    unique case (state_q)
      StClear: begin
        busy_d    = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
        // busy drops on the same edge that writes the last word.
        if (clr_ptr_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end

      StIdle: begin
        if (wr_req) begin
          mem_we    = 1'b1;
          mem_waddr = address;
          if (burst_len != '0) begin
            ptr_d        = address + ADDR_WIDTH'(1);
            beats_left_d = burst_len;
            state_d      = StWrBurst;
          end
        end else if (rd_req) begin
          rd_reg_d = mem_q[address];
          valid_d  = 1'b1;
          if (burst_len != '0) begin
            ptr_d        = address + ADDR_WIDTH'(1);
            beats_left_d = burst_len;
            state_d      = StRdBurst;
          end
        end
      end

      StWrBurst: begin
        if (wr_req) begin
          mem_we       = 1'b1;
          ptr_d        = ptr_q + ADDR_WIDTH'(1);
          beats_left_d = beats_left_q - BURST_BITS'(1);
          if (last_beat) begin
            state_d = StIdle;
          end
        end else begin
          // Any strobe change drops the rest of the burst.
          state_d = StIdle;
        end
      end

      StRdBurst: begin
        if (rd_req) begin
          rd_reg_d     = mem_q[ptr_q];
          valid_d      = 1'b1;
          ptr_d        = ptr_q + ADDR_WIDTH'(1);
          beats_left_d = beats_left_q - BURST_BITS'(1);
          if (last_beat) begin
            state_d = StIdle;
          end
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StClear;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StClear;
      ptr_q        <= '0;
      beats_left_q <= '0;
      clr_ptr_q    <= '0;
      rd_reg_q     <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      beats_left_q <= beats_left_d;
      clr_ptr_q    <= clr_ptr_d;
      rd_reg_q     <= rd_reg_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  // Array storage has no reset; the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;

  // Release is combinational so dropping cs or oe frees the bus immediately.
  assign data = (valid_q & cs & oe & ~we) ? rd_reg_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_burst.sv
// Self-checking bench for sram_burst: directed scenarios followed by random
// bursts, checked against an array model of the memory contents.
module tb_sram_burst;

  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 8;
  localparam int unsigned BB    = 3;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          clk;
  logic          reset;
  logic          cs;
  logic          we;
  logic          oe;
  logic [AW-1:0] address;
  logic [BB-1:0] burst_len;
  wire  [DW-1:0] data;
  logic          busy;
  logic          valid;

  logic          host_en;
  logic [DW-1:0] host_d;
  logic          bus_released;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wbuf  [8];

  int vectors;
  int miscompares;

  assign data         = host_en ? host_d : {DW{1'bz}};
  assign bus_released = (data === {DW{1'bz}});

  sram_burst #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_BITS (BB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .we        (we),
    .oe        (oe),
    .address   (address),
    .burst_len (burst_len),
    .data      (data),
    .busy      (busy),
    .valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [DW-1:0] obs,
                            input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs      = 1'b0;
    we      = 1'b0;
    oe      = 1'b0;
    host_en = 1'b0;
  endtask

  // Reset pulse followed by the clear window. Host write strobes are applied
  // to address 2 during the second half of the clear and must be ignored.
  task automatic do_reset();
    reset = 1'b1;
    step();
    check_bit("reset_busy", busy, 1'b1);
    check_bit("reset_valid", valid, 1'b0);
    idle();
    #1;
    check_bit("reset_bus_z", bus_released, 1'b1);
    reset = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k >= DEPTH / 2) begin
        cs      = 1'b1;
        we      = 1'b1;
        oe      = 1'b0;
        address = AW'(2);
        burst_len = '0;
        host_en = 1'b1;
        host_d  = 8'h55;
      end
      step();
      check_bit("clear_busy", busy, (k < DEPTH) ? 1'b1 : 1'b0);
      check_bit("clear_valid", valid, 1'b0);
    end
    idle();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // n-beat write from wbuf; after abort_at beats the burst is broken by
  // dropping cs (use_rd=0) or by switching to a read pattern (use_rd=1).
  task automatic write_burst(input logic [AW-1:0] a, input int n, input int abort_at,
                             input bit use_rd);
    logic [AW-1:0] ai;
    for (int i = 0; i < abort_at; i++) begin
      cs        = 1'b1;
      we        = 1'b1;
      oe        = 1'b0;
      address   = a;
      burst_len = BB'(n - 1);
      host_en   = 1'b1;
      host_d    = wbuf[i];
      step();
      ai        = a + AW'(i);
      model[ai] = wbuf[i];
      check_bit("wr_valid", valid, 1'b0);
    end
    if (abort_at < n) begin
      host_en = 1'b0;
      if (use_rd) begin
        we = 1'b0;
        oe = 1'b1;
      end else begin
        cs = 1'b0;
      end
      step();
      check_bit("wr_abort_valid", valid, 1'b0);
    end
    idle();
  endtask

  // n-beat read checked beat by beat; abort after abort_at beats by dropping
  // cs (use_ill=0) or by the illegal cs&we&oe pattern (use_ill=1).
  task automatic read_burst(input logic [AW-1:0] a, input int n, input int abort_at,
                            input bit use_ill);
    logic [AW-1:0] ai;
    for (int i = 0; i < abort_at; i++) begin
      cs        = 1'b1;
      we        = 1'b0;
      oe        = 1'b1;
      host_en   = 1'b0;
      address   = a;
      burst_len = BB'(n - 1);
      step();
      ai = a + AW'(i);
      check_bit("rd_valid", valid, 1'b1);
      check_word("rd_data", data, model[ai]);
    end
    if (abort_at < n) begin
      if (use_ill) begin
        we = 1'b1;
      end else begin
        cs = 1'b0;
      end
      step();
      check_bit("rd_abort_valid", valid, 1'b0);
      check_bit("rd_abort_bus_z", bus_released, 1'b1);
      idle();
    end else begin
      idle();
      #1;
      check_bit("rd_release_bus_z", bus_released, 1'b1);
      step();
      check_bit("rd_after_valid", valid, 1'b0);
    end
  endtask

  initial begin
    int n;
    int ab;
    logic [AW-1:0] a;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    address     = '0;
    burst_len   = '0;
    host_d      = '0;
    idle();
    step();

    // Power-up clear; strobes during the clear must not reach address 2.
    do_reset();
    read_burst(AW'(2), 1, 1, 1'b0);

    // Preloaded word is wiped by a later reset.
    wbuf[0] = 8'hAA;
    write_burst(AW'(5), 1, 1, 1'b0);
    read_burst(AW'(5), 1, 1, 1'b0);
    do_reset();
    read_burst(AW'(5), 1, 1, 1'b0);

    // Single write then read.
    wbuf[0] = 8'h81;
    write_burst(AW'(8), 1, 1, 1'b0);
    read_burst(AW'(8), 1, 1, 1'b0);

    // Four-beat burst write and read back.
    wbuf[0] = 8'd73;
    wbuf[1] = 8'd19;
    wbuf[2] = 8'd34;
    wbuf[3] = 8'd5;
    write_burst(AW'(0), 4, 4, 1'b0);
    read_burst(AW'(0), 4, 4, 1'b0);

    // Address wrap at the top of the array.
    wbuf[0] = 8'd1;
    wbuf[1] = 8'd2;
    wbuf[2] = 8'd3;
    write_burst(AW'(126), 3, 3, 1'b0);
    check_word("wrap_model0", model[0], 8'd3);
    read_burst(AW'(126), 3, 3, 1'b0);

    // Abort a write after two beats; mem[18] keeps its old contents.
    wbuf[0] = 8'h3C;
    write_burst(AW'(18), 1, 1, 1'b0);
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    wbuf[2] = 8'h33;
    wbuf[3] = 8'h44;
    write_burst(AW'(16), 4, 2, 1'b0);
    read_burst(AW'(16), 3, 3, 1'b0);
    // Back in idle: a single write lands at its own address.
    wbuf[0] = 8'h5A;
    write_burst(AW'(40), 1, 1, 1'b0);
    read_burst(AW'(40), 1, 1, 1'b0);
    read_burst(AW'(18), 1, 1, 1'b0);

    // Illegal cs&we&oe with the host driving 8'hFF: no write, no read.
    cs        = 1'b1;
    we        = 1'b1;
    oe        = 1'b1;
    address   = AW'(9);
    burst_len = '0;
    host_en   = 1'b1;
    host_d    = 8'hFF;
    step();
    check_bit("illegal_valid", valid, 1'b0);
    host_en = 1'b0;
    #1;
    check_bit("illegal_bus_z", bus_released, 1'b1);
    idle();
    read_burst(AW'(9), 1, 1, 1'b0);

    // Illegal pattern mid read burst aborts it.
    read_burst(AW'(0), 4, 2, 1'b1);
    read_burst(AW'(126), 2, 2, 1'b0);

    // Random bursts, some broken part-way.
    for (int t = 0; t < 40; t++) begin
      a  = AW'($urandom_range(0, DEPTH - 1));
      n  = $urandom_range(1, 8);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : n;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 8; i++) wbuf[i] = DW'($urandom);
        write_burst(a, n, ab, 1'($urandom_range(0, 1)));
      end else begin
        read_burst(a, n, ab, 1'($urandom_range(0, 1)));
      end
    end

    // Reset in the middle of a read burst.
    cs        = 1'b1;
    we        = 1'b0;
    oe        = 1'b1;
    address   = AW'(0);
    burst_len = BB'(3);
    step();
    check_word("midrst_beat0", data, model[0]);
    step();
    check_word("midrst_beat1", data, model[1]);
    do_reset();
    read_burst(AW'(0), 2, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
